// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: state encoding and PC constants.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    WAIT_MEM = 2'd2,
    HALT     = 2'd3
  } seq_state_t;

  localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;
  localparam logic [31:0] RESET_VECTOR    = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bundle between the PC sequencer and the hazard unit, ID branch logic,
// instruction memory, PC register and IF/ID register.
interface pc_sequencer_if #(parameter int CNT_W = 16);
  logic [31:0]      pc_cur;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic             load_use_hazard;
  logic             imem_ready;
  logic             halt_req;
  logic             resume;

  logic             pc_ld;
  logic             pc_clr;
  logic [31:0]      pc_next;
  logic             ifid_ld;
  logic             ifid_flush;
  logic             id_bubble;
  logic             fetch_fault;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  pc_cur, branch_taken, branch_target, jump, jump_target,
           load_use_hazard, imem_ready, halt_req, resume,
    output pc_ld, pc_clr, pc_next, ifid_ld, ifid_flush, id_bubble,
           fetch_fault, stall_cnt
  );

  modport slave (
    output pc_cur, branch_taken, branch_target, jump, jump_target,
           load_use_hazard, imem_ready, halt_req, resume,
    input  pc_ld, pc_clr, pc_next, ifid_ld, ifid_flush, id_bubble,
           fetch_fault, stall_cnt
  );
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + ONE;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage sequencer: picks PC+step, redirect or replayed target, and drives
// PC / IF/ID load, clear and flush controls across stalls, memory waits and halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_STEP      = DEFAULT_PC_STEP,
  parameter int          WAIT_TIMEOUT = 15,
  parameter int          CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

  seq_state_t  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        fault_q, fault_d;

  logic        pc_ld, pc_clr, ifid_ld, ifid_flush, id_bubble;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] seq_pc;
  logic        stall_inc;
  logic [CNT_W-1:0] stall_cnt;

  assign redirect        = bus.branch_taken || bus.jump;
  assign redirect_target = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign seq_pc          = bus.pc_cur + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      wait_q        <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= RESET_VECTOR;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      fault_q       <= fault_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    fault_d       = fault_q;
    pc_ld         = 1'b0;
    pc_clr        = 1'b0;
    ifid_ld       = 1'b0;
    ifid_flush    = 1'b0;
    id_bubble     = 1'b0;
    pc_next       = seq_pc;

    unique case (state_q)
      BOOT: begin
        pc_clr     = 1'b1;
        ifid_flush = 1'b1;
        pc_next    = RESET_VECTOR;
        state_d    = FETCH;
      end

      FETCH: begin
        if (bus.halt_req) begin
          ifid_flush   = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = HALT;
        end else if (bus.load_use_hazard) begin
          // Redirect is dropped here; ID re-presents it once operands are ready.
          id_bubble = 1'b1;
        end else if (redirect) begin
          pc_ld      = 1'b1;
          pc_next    = redirect_target;
          ifid_flush = 1'b1;
        end else if (pend_valid_q) begin
          pc_ld        = 1'b1;
          pc_next      = pend_target_q;
          ifid_flush   = 1'b1;
          pend_valid_d = 1'b0;
        end else if (!bus.imem_ready) begin
          ifid_flush = 1'b1;
          wait_d     = 8'd1;
          state_d    = WAIT_MEM;
        end else begin
          pc_ld   = 1'b1;
          ifid_ld = 1'b1;
        end
      end

      WAIT_MEM: begin
        ifid_flush = 1'b1;
        if (redirect) begin
          pend_valid_d  = 1'b1;
          pend_target_d = redirect_target;
        end
        if (bus.halt_req) begin
          pend_valid_d = 1'b0;
          wait_d       = '0;
          state_d      = HALT;
        end else if (bus.imem_ready) begin
          wait_d  = '0;
          state_d = FETCH;
        end else if (wait_q == TIMEOUT_CNT) begin
          fault_d = 1'b1;
          wait_d  = '0;
          state_d = HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      HALT: begin
        ifid_flush = 1'b1;
        if (bus.resume && !bus.halt_req) state_d = FETCH;
      end

      default: state_d = BOOT;
    endcase
  end

  assign stall_inc = ((state_q == FETCH) || (state_q == WAIT_MEM)) && !pc_ld;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  assign bus.pc_ld       = pc_ld;
  assign bus.pc_clr      = pc_clr;
  assign bus.pc_next     = pc_next;
  assign bus.ifid_ld     = ifid_ld;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.id_bubble   = id_bubble;
  assign bus.fetch_fault = fault_q;
  assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a behavioural model of its rules.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_W(16)) bus ();
  pc_sequencer_if #(.CNT_W(4))  bus4 ();

  pc_sequencer #(.WAIT_TIMEOUT(15), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  pc_sequencer #(.WAIT_TIMEOUT(15), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Narrow-counter copy sees identical stimulus; only its stall count is checked.
  assign bus4.pc_cur          = bus.pc_cur;
  assign bus4.branch_taken    = bus.branch_taken;
  assign bus4.branch_target   = bus.branch_target;
  assign bus4.jump            = bus.jump;
  assign bus4.jump_target     = bus.jump_target;
  assign bus4.load_use_hazard = bus.load_use_hazard;
  assign bus4.imem_ready      = bus.imem_ready;
  assign bus4.halt_req        = bus.halt_req;
  assign bus4.resume          = bus.resume;

  typedef enum {M_BOOT, M_RUN, M_MEMWAIT, M_FROZEN} mode_t;

  int errors = 0;
  int checks = 0;

  // Reference model state
  mode_t       m_mode;
  int          m_wait;
  bit          m_pv;
  logic [31:0] m_pt;
  bit          m_fault;
  int          m_stall;

  // Expected outputs and model next state
  bit          e_ld, e_clr, e_ild, e_flush, e_bub;
  logic [31:0] e_next;
  mode_t       n_mode;
  int          n_wait;
  bit          n_pv;
  logic [31:0] n_pt;
  bit          n_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_wait = 0; m_pv = 0; m_pt = '0; m_fault = 0; m_stall = 0;
  endtask

  task automatic model_eval();
    bit          redir;
    logic [31:0] tgt;
    redir = bus.branch_taken || bus.jump;
    tgt   = bus.branch_taken ? bus.branch_target : bus.jump_target;
    e_ld = 0; e_clr = 0; e_ild = 0; e_flush = 0; e_bub = 0;
    e_next = bus.pc_cur + 32'd4;
    n_mode = m_mode; n_wait = m_wait; n_pv = m_pv; n_pt = m_pt; n_fault = m_fault;
    if (m_mode == M_BOOT) begin
      e_clr = 1; e_flush = 1; e_next = 32'h0; n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (bus.halt_req) begin
        e_flush = 1; n_pv = 0; n_mode = M_FROZEN;
      end else if (bus.load_use_hazard) begin
        e_bub = 1;
      end else if (redir) begin
        e_ld = 1; e_next = tgt; e_flush = 1;
      end else if (m_pv) begin
        e_ld = 1; e_next = m_pt; e_flush = 1; n_pv = 0;
      end else if (!bus.imem_ready) begin
        e_flush = 1; n_wait = 1; n_mode = M_MEMWAIT;
      end else begin
        e_ld = 1; e_ild = 1;
      end
    end else if (m_mode == M_MEMWAIT) begin
      e_flush = 1;
      if (redir) begin n_pv = 1; n_pt = tgt; end
      if (bus.halt_req) begin
        n_pv = 0; n_mode = M_FROZEN;
      end else if (bus.imem_ready) begin
        n_wait = 0; n_mode = M_RUN;
      end else if (m_wait == 15) begin
        n_fault = 1; n_mode = M_FROZEN;
      end else begin
        n_wait = m_wait + 1;
      end
    end else begin
      e_flush = 1;
      if (bus.resume && !bus.halt_req) n_mode = M_RUN;
    end
  endtask

  task automatic compare_outputs();
    check("pc_ld",       bus.pc_ld,       e_ld);
    check("pc_clr",      bus.pc_clr,      e_clr);
    check("ifid_ld",     bus.ifid_ld,     e_ild);
    check("ifid_flush",  bus.ifid_flush,  e_flush);
    check("id_bubble",   bus.id_bubble,   e_bub);
    check("fetch_fault", bus.fetch_fault, m_fault);
    check("stall_cnt",   bus.stall_cnt,   m_stall);
    check("stall_cnt4",  bus4.stall_cnt,  (m_stall > 15) ? 15 : m_stall);
    check("excl_pc",     bus.pc_ld & bus.pc_clr, 1'b0);
    check("excl_ifid",   bus.ifid_ld & bus.ifid_flush, 1'b0);
    if (e_ld || e_clr) check("pc_next", bus.pc_next, e_next);
  endtask

  // One clock: check settled outputs, advance model on the edge, follow the PC register.
  task automatic cycle();
    #1;
    model_eval();
    compare_outputs();
    @(posedge clk);
    if (((m_mode == M_RUN) || (m_mode == M_MEMWAIT)) && !e_ld && m_stall < 65535) m_stall++;
    m_mode = n_mode; m_wait = n_wait; m_pv = n_pv; m_pt = n_pt; m_fault = n_fault;
    @(negedge clk);
    if (e_clr)     bus.pc_cur = 32'h0;
    else if (e_ld) bus.pc_cur = e_next;
  endtask

  task automatic quiet_inputs();
    bus.branch_taken = 0; bus.branch_target = '0; bus.jump = 0; bus.jump_target = '0;
    bus.load_use_hazard = 0; bus.imem_ready = 1; bus.halt_req = 0; bus.resume = 0;
  endtask

  // Asynchronous reset pulse asserted mid-cycle, outputs checked before any edge.
  task automatic pulse_reset();
    rst = 1;
    #1;
    model_reset();
    model_eval();
    compare_outputs();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int burst;
    quiet_inputs();
    bus.pc_cur = 32'h0;
    model_reset();

    // Reset state
    #2;
    model_eval();
    compare_outputs();
    check("rst_pc_next", bus.pc_next, 32'h0);
    @(negedge clk);
    rst = 0;

    // BOOT then sequential fetch 4, 8, 12
    repeat (4) cycle();
    check("seq_pc_cur", bus.pc_cur, 32'd12);

    // Branch beats jump
    bus.pc_cur = 32'h40;
    bus.branch_taken = 1; bus.branch_target = 32'h100;
    bus.jump = 1; bus.jump_target = 32'h200;
    cycle();
    quiet_inputs();

    // Load-use hazard suppresses redirect, then redirect
    bus.pc_cur = 32'h20;
    bus.load_use_hazard = 1; bus.branch_taken = 1; bus.branch_target = 32'h80;
    cycle();
    bus.load_use_hazard = 0;
    cycle();
    check("hazard_redirect_pc", bus.pc_cur, 32'h80);
    quiet_inputs();

    // Memory wait with pending jump replayed
    bus.imem_ready = 0;
    cycle();
    bus.jump = 1; bus.jump_target = 32'h300;
    cycle();
    bus.jump = 0;
    cycle();
    bus.imem_ready = 1;
    cycle();
    cycle();
    check("pend_replay_pc", bus.pc_cur, 32'h300);

    // PC wrap
    bus.pc_cur = 32'hFFFF_FFFC;
    cycle();
    check("wrap_pc", bus.pc_cur, 32'h0);

    // Timeout to fault and HALT, resume, fault stays sticky
    bus.imem_ready = 0;
    repeat (17) cycle();
    check("timeout_fault", bus.fetch_fault, 1'b1);
    bus.imem_ready = 1; bus.resume = 1;
    cycle();
    bus.resume = 0;
    repeat (3) cycle();
    check("fault_sticky", bus.fetch_fault, 1'b1);

    // Halt for six stalled cycles, then resume
    bus.halt_req = 1;
    cycle();
    bus.halt_req = 0;
    repeat (4) cycle();
    bus.resume = 1;
    cycle();
    bus.resume = 0;
    repeat (2) cycle();

    // Reset while halted
    bus.halt_req = 1;
    cycle();
    bus.halt_req = 0;
    cycle();
    pulse_reset();
    check("rst_mid_fault", bus.fetch_fault, 1'b0);
    repeat (2) cycle();

    // Randomized traffic with memory-wait bursts and occasional resets
    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      bus.branch_taken    = ($urandom_range(99, 0) < 10);
      bus.branch_target   = {$urandom_range(32'hFFFF, 0), 16'h0} | ($urandom_range(255, 0) << 2);
      bus.jump            = ($urandom_range(99, 0) < 8);
      bus.jump_target     = $urandom() & 32'hFFFF_FFFC;
      bus.load_use_hazard = ($urandom_range(99, 0) < 10);
      bus.resume          = ($urandom_range(99, 0) < 30);
      if (burst == 0 && $urandom_range(99, 0) < 3) burst = $urandom_range(20, 8);
      if (burst > 0) begin
        burst--;
        bus.imem_ready = 0;
        bus.halt_req   = 0;
      end else begin
        bus.imem_ready = ($urandom_range(99, 0) < 80);
        bus.halt_req   = ($urandom_range(99, 0) < 3);
      end
      if ($urandom_range(999, 0) < 4) pulse_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
